// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit: formats byte/half/word accesses for a word-wide SRAM and
// holds the pipeline in stall from the request cycle until mem_ready or timeout, then releases it for one DONE cycle.
module dmem_access_unit #(
   parameter int ADDR_W  = 32,
   parameter int MEM_AW  = 7,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [2:0]        funct3,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              misalign,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;
   state_t r_state, w_next;

   logic              w_req, w_is_b, w_is_h, w_misalign, w_go, w_timeout;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_load;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;
   logic              w_unused_addr;

   logic              r_we, r_uns, r_is_b, r_is_h, r_bus_err;
   logic [1:0]        r_lane;
   logic [3:0]        r_be;
   logic [MEM_AW-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_rdata;
   logic [CNT_W-1:0]  r_cnt;

   assign w_req         = req_read | req_write;
   assign w_is_b        = (funct3[1:0] == 2'b00);
   assign w_is_h        = (funct3[1:0] == 2'b01);
   assign w_misalign    = w_is_h ? addr[0] : (!w_is_b && (addr[1:0] != 2'b00));
   assign w_go          = (r_state == S_IDLE) && w_req && !w_misalign;
   assign w_timeout     = (r_state == S_WAIT) && !mem_ready && (r_cnt == CNT_W'(TIMEOUT - 1));
   assign w_unused_addr = ^addr[ADDR_W-1:MEM_AW+2];

   // Undefined funct3 sizes fall through to word
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      if (w_is_b) begin
         w_be    = 4'b0001 << addr[1:0];
         w_wdata = {4{wdata[7:0]}};
      end else if (w_is_h) begin
         w_be    = addr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{wdata[15:0]}};
      end
   end

   assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

   always_comb begin
      w_load = mem_rdata;
      if (r_is_b)
         w_load = {{(DATA_W-8){!r_uns & w_byte[7]}}, w_byte};
      else if (r_is_h)
         w_load = {{(DATA_W-16){!r_uns & w_half[15]}}, w_half};
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_go) w_next = S_WAIT;
         S_WAIT:  if (mem_ready || w_timeout) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      stall     = 1'b0;
      misalign  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_be    = '0;
      mem_wdata = '0;
      case (r_state)
         S_IDLE: begin
            misalign = w_req && w_misalign;
            if (w_go) begin
               stall     = 1'b1;
               mem_req   = 1'b1;
               mem_we    = req_write;
               mem_addr  = addr[MEM_AW+1:2];
               mem_be    = w_be;
               mem_wdata = w_wdata;
            end
         end
         S_WAIT: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = r_we;
            mem_addr  = r_addr;
            mem_be    = r_be;
            mem_wdata = r_wdata;
         end
         default: ;
      endcase
   end

   // Captured access keeps the SRAM interface stable for the whole WAIT phase
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_is_b    <= 1'b0;
         r_is_h    <= 1'b0;
         r_lane    <= '0;
         r_be      <= '0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_cnt     <= '0;
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
         if (w_go) begin
            r_we    <= req_write;
            r_uns   <= funct3[2];
            r_is_b  <= w_is_b;
            r_is_h  <= w_is_h;
            r_lane  <= addr[1:0];
            r_be    <= w_be;
            r_addr  <= addr[MEM_AW+1:2];
            r_wdata <= w_wdata;
            r_cnt   <= '0;
         end else if (r_state == S_WAIT && r_cnt != CNT_W'(TIMEOUT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (r_state == S_WAIT) begin
            if (mem_ready) begin
               if (!r_we) r_rdata <= w_load;
            end else if (w_timeout) begin
               r_rdata <= '0;
            end
         end
      end
   end

   assign rdata   = r_rdata;
   assign bus_err = r_bus_err;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed scenarios plus random accesses against a byte-level memory model.
module tb_dmem_access_unit;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_read, req_write;
   logic [31:0] addr, wdata;
   logic [2:0]  funct3;
   logic        stall, misalign, bus_err, mem_req, mem_we, mem_ready;
   logic [31:0] rdata, mem_wdata, mem_rdata;
   logic [6:0]  mem_addr;
   logic [3:0]  mem_be;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] model_mem [128];
   logic [31:0] exp_rdata;

   dmem_access_unit #(.ADDR_W(32), .MEM_AW(7), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .addr(addr), .wdata(wdata), .funct3(funct3), .stall(stall), .rdata(rdata),
      .misalign(misalign), .bus_err(bus_err), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Lane extraction and extension computed arithmetically from the access rules
   function automatic logic [31:0] model_load(input logic [31:0] w, input int off, input logic [2:0] f3);
      int unsigned sh, b, h;
      int          v;
      sh = w >> (8 * off);
      b  = sh & 32'hFF;
      h  = sh & 32'hFFFF;
      case (f3)
         3'b000:  v = (b >= 128) ? int'(b) - 256 : int'(b);
         3'b100:  v = int'(b);
         3'b001:  v = (h >= 32768) ? int'(h) - 65536 : int'(h);
         3'b101:  v = int'(h);
         default: v = int'(w);
      endcase
      return 32'(v);
   endfunction

   // lat = WAIT cycles before mem_ready; lat >= TIMEOUT means the SRAM never answers
   task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [2:0] f3, input int lat);
      int          size, off, stall_cnt, exp_stall;
      bit          mis, done;
      logic [3:0]  ebe;
      logic [31:0] ewd;
      logic [6:0]  ea;
      off  = int'(a[1:0]);
      size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      mis  = (off % size) != 0;
      ea   = a[8:2];
      ebe  = (size == 1) ? 4'(1 << off) : (size == 2) ? 4'(3 << off) : 4'hF;
      ewd  = (size == 1) ? wd[7:0] * 32'h01010101 : (size == 2) ? wd[15:0] * 32'h00010001 : wd;

      @(negedge clk);
      req_read = rd; req_write = wr; addr = a; wdata = wd; funct3 = f3;
      mem_ready = 1'b0; mem_rdata = $urandom;
      #1;
      if (!rd && !wr) begin
         check_eq("noreq_mem_req", mem_req, 0);
         check_eq("noreq_stall", stall, 0);
         return;
      end
      if (mis) begin
         check_eq("mis_pulse", misalign, 1);
         check_eq("mis_stall", stall, 0);
         check_eq("mis_mem_req", mem_req, 0);
         @(negedge clk);
         req_read = 1'b0; req_write = 1'b0;
         #1;
         check_eq("mis_pulse_end", misalign, 0);
         check_eq("mis_mem_req_after", mem_req, 0);
         check_eq("mis_rdata", rdata, exp_rdata);
         return;
      end
      check_eq("req_misalign", misalign, 0);
      check_eq("req_mem_req", mem_req, 1);
      check_eq("req_we", mem_we, wr);
      check_eq("req_addr", mem_addr, ea);
      check_eq("req_be", mem_be, ebe);
      check_eq("req_wdata", mem_wdata, ewd);
      stall_cnt = int'(stall);
      done = 1'b0;
      for (int w = 0; w < TIMEOUT && !done; w++) begin
         @(negedge clk);
         mem_ready = (w == lat);
         mem_rdata = (w == lat) ? model_mem[ea] : $urandom;
         #1;
         stall_cnt += int'(stall);
         check_eq("wait_mem_req", mem_req, 1);
         check_eq("wait_addr", mem_addr, ea);
         check_eq("wait_be", mem_be, ebe);
         check_eq("wait_wdata", mem_wdata, ewd);
         check_eq("wait_we", mem_we, wr);
         if (w == lat) done = 1'b1;
      end
      if (!done) exp_rdata = 32'h0;
      else if (wr) begin
         for (int i = 0; i < 4; i++)
            if (ebe[i]) model_mem[ea][8*i +: 8] = ewd[8*i +: 8];
      end else exp_rdata = model_load(model_mem[ea], off, f3);
      exp_stall = done ? lat + 2 : TIMEOUT + 1;

      // DONE cycle: junk request and stray mem_ready must be ignored
      @(negedge clk);
      mem_ready = 1'($urandom); mem_rdata = $urandom;
      req_read = 1'($urandom); req_write = 1'($urandom); addr = $urandom; funct3 = 3'($urandom);
      #1;
      check_eq("done_stall", stall, 0);
      check_eq("done_mem_req", mem_req, 0);
      check_eq("done_be", mem_be, 0);
      check_eq("done_misalign", misalign, 0);
      check_eq("done_bus_err", bus_err, !done);
      check_eq("done_rdata", rdata, exp_rdata);
      check_eq("stall_cycles", stall_cnt, exp_stall);
      @(negedge clk);
      req_read = 1'b0; req_write = 1'b0; mem_ready = 1'b0;
      #1;
      check_eq("idle_stall", stall, 0);
      check_eq("idle_mem_req", mem_req, 0);
      check_eq("idle_bus_err", bus_err, 0);
      check_eq("idle_rdata", rdata, exp_rdata);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 128; i++) model_mem[i] = $urandom;
      exp_rdata = 32'h0;
      reset = 1'b1; req_read = 1'b0; req_write = 1'b0; addr = '0; wdata = '0;
      funct3 = '0; mem_ready = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_stall", stall, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_mem_req", mem_req, 0);
      check_eq("rst_bus_err", bus_err, 0);
      check_eq("rst_misalign", misalign, 0);
      @(negedge clk);
      reset = 1'b0;

      access(0, 1, 32'h10, 32'hDEADBEEF, 3'b010, 0);
      check_eq("sw_mem_word", model_mem[4], 32'hDEADBEEF);
      model_mem[4] = 32'h80FF7F01;
      access(1, 0, 32'h13, 32'h0, 3'b000, 0);
      check_eq("lb_plan", rdata, 32'hFFFFFF80);
      access(1, 0, 32'h13, 32'h0, 3'b100, 0);
      check_eq("lbu_plan", rdata, 32'h00000080);
      model_mem[4] = 32'h80011234;
      access(1, 0, 32'h12, 32'h0, 3'b001, 1);
      check_eq("lh_plan", rdata, 32'hFFFF8001);
      access(1, 0, 32'h12, 32'h0, 3'b101, 2);
      check_eq("lhu_plan", rdata, 32'h00008001);
      access(0, 1, 32'h06, 32'h1234ABCD, 3'b001, 1);
      access(1, 0, 32'h22, 32'h0, 3'b010, 0);
      access(1, 1, 32'h44, 32'hCAFEF00D, 3'b111, 0);
      access(1, 0, 32'h30, 32'h0, 3'b010, TIMEOUT + 5);
      check_eq("timeout_rdata", rdata, 32'h0);

      // Reset in the third WAIT cycle abandons the access
      access(1, 0, 32'h12, 32'h0, 3'b001, 0);
      @(negedge clk);
      req_read = 1'b1; addr = 32'h40; funct3 = 3'b010; mem_ready = 1'b0;
      repeat (2) @(negedge clk);
      @(negedge clk);
      reset = 1'b1; req_read = 1'b0; mem_ready = 1'b1; mem_rdata = $urandom;
      @(negedge clk);
      reset = 1'b0; mem_ready = 1'b0;
      #1;
      check_eq("rstw_stall", stall, 0);
      check_eq("rstw_mem_req", mem_req, 0);
      check_eq("rstw_rdata", rdata, 0);
      check_eq("rstw_bus_err", bus_err, 0);
      check_eq("rstw_be", mem_be, 0);
      exp_rdata = 32'h0;
      access(1, 0, 32'h40, 32'h0, 3'b010, 0);

      for (int k = 0; k < 60; k++) begin
         int r;
         r = $urandom_range(0, 7);
         access(1'($urandom), 1'($urandom), $urandom, $urandom, 3'($urandom),
                (r == 7) ? TIMEOUT + 3 : r % 4);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
